// File: rtl/reg_file_wb_if.sv
// Bus bundle between the write-back / decode stages and the register file.
// Carries the RegWrite strobe, the write index and data, both read ports,
// and the commit status outputs.
// master: the datapath side (drives write and read indices, samples the results).
// slave : the register file (drives read data and commit status).
interface reg_file_wb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              RegWrite;
  logic [4:0]        Write_Register;
  logic [DATA_W-1:0] Write_Data;
  logic [4:0]        Read_Register1;
  logic [4:0]        Read_Register2;
  logic [DATA_W-1:0] Read_Data1;
  logic [DATA_W-1:0] Read_Data2;
  logic [31:0]       wr_onehot;
  logic [CNT_W-1:0]  commit_count;
  logic [4:0]        last_wr_addr;

  modport master (
    output RegWrite, Write_Register, Write_Data, Read_Register1, Read_Register2,
    input  Read_Data1, Read_Data2, wr_onehot, commit_count, last_wr_addr
  );

  modport slave (
    input  RegWrite, Write_Register, Write_Data, Read_Register1, Read_Register2,
    output Read_Data1, Read_Data2, wr_onehot, commit_count, last_wr_addr
  );
endinterface

// File: rtl/reg_file_wb.sv
// 32 x DATA_W MIPS register file with write-back commit tracking.
// r0 reads as zero and ignores writes; r28/r29 reset to GP_INIT/SP_INIT.
// Two combinational read ports with same-cycle write-to-read bypass.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   bus (slave)       : RegWrite/Write_Register/Write_Data write port,
//                       Read_Register1/2 -> Read_Data1/2 (combinational),
//                       wr_onehot, commit_count, last_wr_addr (registered)
// Optional build macro REGFILE_TRACE_EN adds simulation-only commit/warning
// displays; function and timing are identical with or without it.
module reg_file_wb #(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h0000_3FFC),
  parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(32'h0000_1800),
  parameter int unsigned       CNT_W   = 16
) (
  input logic           clk,
  input logic           reset,
  reg_file_wb_if.slave  bus
);

  localparam int unsigned NREGS = 32;

  logic [DATA_W-1:0] regs [NREGS];
  logic [31:0]       wr_onehot_q;
  logic [CNT_W-1:0]  count_q;
  logic [4:0]        last_q;

  logic              commit_c;
  logic              byp_c;
  logic [DATA_W-1:0] rd1_c;
  logic [DATA_W-1:0] rd2_c;

  // An unknown RegWrite makes these unknown, which the if-branches below
  // treat as false: no commit and no bypass.
  assign commit_c = bus.RegWrite && (bus.Write_Register != 5'd0);
  assign byp_c    = bus.RegWrite && !reset;

  // Storage and commit status; reset takes priority over any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      regs[28]    <= GP_INIT;
      regs[29]    <= SP_INIT;
      wr_onehot_q <= '0;
      count_q     <= '0;
      last_q      <= '0;
    end else if (commit_c) begin
      regs[bus.Write_Register] <= bus.Write_Data;
      wr_onehot_q              <= 32'(1) << bus.Write_Register;
      count_q                  <= count_q + CNT_W'(1);
      last_q                   <= bus.Write_Register;
    end else begin
      wr_onehot_q <= '0;
    end
  end

  // Read port 1: zero register, then bypass, then storage.
  always_comb begin
    rd1_c = regs[bus.Read_Register1];
    if (bus.Read_Register1 == 5'd0) begin
      rd1_c = '0;
    end else if (byp_c && (bus.Read_Register1 == bus.Write_Register)) begin
      rd1_c = bus.Write_Data;
    end
  end

  // Read port 2: same priority chain as port 1.
  always_comb begin
    rd2_c = regs[bus.Read_Register2];
    if (bus.Read_Register2 == 5'd0) begin
      rd2_c = '0;
    end else if (byp_c && (bus.Read_Register2 == bus.Write_Register)) begin
      rd2_c = bus.Write_Data;
    end
  end

  assign bus.Read_Data1   = rd1_c;
  assign bus.Read_Data2   = rd2_c;
  assign bus.wr_onehot    = wr_onehot_q;
  assign bus.commit_count = count_q;
  assign bus.last_wr_addr = last_q;

`ifdef REGFILE_TRACE_EN
  // Simulation-only trace of commits and suspicious write attempts.
  always @(posedge clk) begin
    if (!reset) begin
      if ($isunknown(bus.RegWrite) || $isunknown(bus.Write_Register)) begin
        $display("%t reg_file_wb ERROR: unknown RegWrite/Write_Register", $time);
      end else if (bus.RegWrite) begin
        if (bus.Write_Register == 5'd0) begin
          if (bus.Write_Data != '0) begin
            $display("%t reg_file_wb WARNING: write of %h to r0 discarded",
                     $time, bus.Write_Data);
          end
        end else begin
          $display("%t reg_file_wb commit r%h <= %h",
                   $time, bus.Write_Register, bus.Write_Data);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb built with CNT_W = 4 so the counter wrap is
// reachable quickly. Expectations are queued when a step is driven and
// popped when the corresponding DUT output is sampled.
module tb_reg_file_wb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  reg_file_wb_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  reg_file_wb #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference commit status, advanced by step_edge.
  int unsigned m_cnt  = 0;
  logic [4:0]  m_last = '0;
  logic [31:0] m_oh   = '0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Clock one edge and advance the reference status model.
  task automatic step_edge();
    logic we;
    logic [4:0] a;
    we = (bus.RegWrite === 1'b1);
    a  = bus.Write_Register;
    @(posedge clk);
    if (reset) begin
      m_cnt = 0; m_last = '0; m_oh = '0;
    end else if (we && a != 5'd0) begin
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      m_last = a;
      m_oh   = 32'h1 << a;
    end else begin
      m_oh = '0;
    end
    #1;
  endtask

  task automatic check_status(input string pfx);
    push({pfx, "_cnt"}, 32'(m_cnt));
    check(32'(bus.commit_count));
    push({pfx, "_oh"}, m_oh);
    check(bus.wr_onehot);
    push({pfx, "_last"}, 32'(m_last));
    check(32'(bus.last_wr_addr));
  endtask

  task automatic read1(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    bus.Read_Register1 = idx;
    push(tag, exp);
    #1;
    check(bus.Read_Data1);
  endtask

  task automatic read2(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    bus.Read_Register2 = idx;
    push(tag, exp);
    #1;
    check(bus.Read_Data2);
  endtask

  initial begin
    reset = 1'b1;
    bus.RegWrite = 1'b0;
    bus.Write_Register = '0;
    bus.Write_Data = '0;
    bus.Read_Register1 = '0;
    bus.Read_Register2 = '0;

    // Reset then read
    step_edge();
    reset = 1'b0;
    read1("rst_r0", 5'd0, 32'h0);
    read2("rst_r5", 5'd5, 32'h0);
    read1("rst_r28", 5'd28, 32'h0000_1800);
    read2("rst_r29", 5'd29, 32'h0000_3FFC);
    push("rst_cnt", 32'h0);   check(32'(bus.commit_count));
    push("rst_oh", 32'h0);    check(bus.wr_onehot);
    push("rst_last", 32'h0);  check(32'(bus.last_wr_addr));

    // Basic write/read
    bus.RegWrite = 1'b1; bus.Write_Register = 5'd8; bus.Write_Data = 32'hDEAD_BEEF;
    step_edge();
    bus.RegWrite = 1'b0;
    read1("wr_r8", 5'd8, 32'hDEAD_BEEF);
    push("wr_oh", 32'h0000_0100); check(bus.wr_onehot);
    push("wr_last", 32'd8);       check(32'(bus.last_wr_addr));
    push("wr_cnt", 32'd1);        check(32'(bus.commit_count));

    // Bypass on both ports, other port unaffected
    bus.RegWrite = 1'b1; bus.Write_Register = 5'd31; bus.Write_Data = 32'h0040_0010;
    read1("byp_p1", 5'd31, 32'h0040_0010);
    read2("byp_p2", 5'd31, 32'h0040_0010);
    read2("byp_other", 5'd8, 32'hDEAD_BEEF);
    bus.Read_Register2 = 5'd31;
    step_edge();
    bus.RegWrite = 1'b0;
    read1("byp_stored", 5'd31, 32'h0040_0010);
    read2("byp_stored2", 5'd31, 32'h0040_0010);
    check_status("byp");

    // Zero register write is discarded
    bus.RegWrite = 1'b1; bus.Write_Register = 5'd0; bus.Write_Data = 32'hFFFF_FFFF;
    read1("r0_same", 5'd0, 32'h0);
    step_edge();
    bus.RegWrite = 1'b0;
    read1("r0_next", 5'd0, 32'h0);
    push("r0_cnt", 32'd2); check(32'(bus.commit_count));
    push("r0_oh", 32'h0);  check(bus.wr_onehot);
    check_status("r0");

    // Give r9 a known value so the reset cycle shows stored data, not bypass
    bus.RegWrite = 1'b1; bus.Write_Register = 5'd9; bus.Write_Data = 32'h5555_0000;
    step_edge();

    // Reset mid-operation with a write pending
    reset = 1'b1;
    bus.Write_Register = 5'd9; bus.Write_Data = 32'h0000_1234;
    read1("rstw_nobyp", 5'd9, 32'h5555_0000);
    step_edge();
    reset = 1'b0;
    bus.RegWrite = 1'b0;
    read1("rstw_r9", 5'd9, 32'h0);
    read2("rstw_r8", 5'd8, 32'h0);
    read1("rstw_r28", 5'd28, 32'h0000_1800);
    push("rstw_cnt", 32'h0); check(32'(bus.commit_count));
    check_status("rstw");

    // Counter wrap at CNT_W = 4
    bus.RegWrite = 1'b1; bus.Write_Register = 5'd3;
    for (int i = 1; i <= 17; i++) begin
      bus.Write_Data = 32'(i) * 32'h0101_0101;
      step_edge();
      if (i == 15) begin
        push("wrap_15", 32'd15); check(32'(bus.commit_count));
      end else if (i == 16) begin
        push("wrap_16", 32'd0);  check(32'(bus.commit_count));
      end
    end
    bus.RegWrite = 1'b0;
    push("wrap_17", 32'd1); check(32'(bus.commit_count));
    read1("wrap_r3", 5'd3, 32'h1111_1111);
    check_status("wrap");

    // Unknown RegWrite: no commit, no bypass
    bus.RegWrite = 1'bx; bus.Write_Register = 5'd4; bus.Write_Data = 32'h0000_AAAA;
    read1("x_nobyp", 5'd4, 32'h0);
    step_edge();
    bus.RegWrite = 1'b0;
    read1("x_r4", 5'd4, 32'h0);
    check_status("x");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Register file and write-back endpoint for the single-cycle MIPS datapath.
- Consumes the 5-bit destination index produced by the RegDst destination-select stage (rt, rd or $ra) together with the write-back data and RegWrite strobe.
- Decodes the index into a one-hot write enable and commits on the clock edge.
- Serves two combinational read ports to the decode/ALU stage, with same-cycle write-to-read bypass.

Parameters:
- DATA_W, 32, register width in bits.
- SP_INIT, 32'h0000_3FFC, reset value of register 29 ($sp).
- GP_INIT, 32'h0000_1800, reset value of register 28 ($gp).
- CNT_W, 16, width of the commit counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write-back strobe; commit on this clk edge when high.
- Write_Register  input  5  destination index from the RegDst select stage.
- Write_Data  input  DATA_W  write-back value.
- Read_Register1  input  5  read port 1 index (rs).
- Read_Register2  input  5  read port 2 index (rt).
- Read_Data1  output  DATA_W  read port 1 data, combinational.
- Read_Data2  output  DATA_W  read port 2 data, combinational.
- wr_onehot  output  32  registered one-hot of the last committed destination; 0 if no commit last cycle.
- commit_count  output  CNT_W  number of committed non-zero-index writes since reset.
- last_wr_addr  output  5  index of the most recent committed write.

Behaviour:
- Storage is 32 x DATA_W.
- Register 0 is hardwired to 0. Writes to index 0 are discarded: no storage change, no count, wr_onehot = 0 next cycle.
- Reset, sampled on the rising clk edge with reset = 1, completes in one cycle:
  - all registers = 0, except r28 = GP_INIT and r29 = SP_INIT;
  - wr_onehot = 0, commit_count = 0, last_wr_addr = 0.
- Reset dominates RegWrite. A write presented in the reset cycle is lost.
- Commit: on the rising edge with reset = 0, RegWrite = 1 and Write_Register = N with N != 0:
  - reg[N] <= Write_Data;
  - wr_onehot <= (1 << N);
  - last_wr_addr <= N;
  - commit_count <= commit_count + 1, wrapping modulo 2^CNT_W (all-ones -> 0, no saturation).
- When RegWrite = 0 or N = 0: wr_onehot <= 0; commit_count and last_wr_addr hold.
- Write latency: one edge. A value is visible from storage on the cycle after the commit.
- Reads are combinational, with a priority chain per port:
  1. index 0 -> 0;
  2. RegWrite = 1, reset = 0 and index == Write_Register -> Write_Data (bypass, same cycle);
  3. otherwise stored value.
- Bypass is disabled while reset = 1. Reads then return stored contents.
- Both ports may address the same register. Both return an identical value, including the bypass case.
- Write_Register values are always 0..31; there are no illegal indices, so every value decodes.
- Unknown (X/Z) on RegWrite is treated as no write: nothing commits. There is no X propagation into storage.

Optional Feature:
- Macro: REGFILE_TRACE_EN.
- Defined:
  - each commit issues a simulation-only display of time, index and data, in hex;
  - every attempted write to index 0 with non-zero data issues a warning display;
  - an X/Z on RegWrite or Write_Register issues an error display.
- Undefined: no display statements are compiled. Function and timing are identical in both builds.

Test Plan:
- Reset then read: reset = 1 for one edge -> r0 = 0, r5 = 0, r28 = 32'h1800, r29 = 32'h3FFC, commit_count = 0, wr_onehot = 0.
- Basic write/read: RegWrite = 1, Write_Register = 8, Write_Data = 32'hDEADBEEF, one edge; then Read_Register1 = 8 -> Read_Data1 = 32'hDEADBEEF, wr_onehot = 32'h100, last_wr_addr = 8, commit_count = 1.
- Bypass: same cycle RegWrite = 1, Write_Register = 31, Write_Data = 32'h0040_0010 (jal link), Read_Register1 = Read_Register2 = 31 -> both reads 32'h0040_0010 before the edge; after the edge, storage r31 = 32'h0040_0010.
- Zero register: write 32'hFFFF_FFFF to index 0 -> Read_Data1 at index 0 = 0 in the same and the next cycle; commit_count unchanged; wr_onehot = 0.
- Reset mid-operation: RegWrite = 1, Write_Register = 9, Write_Data = 32'h1234 with reset = 1 -> r9 = 0 after the edge, no bypass during that cycle, commit_count = 0.
- Counter wrap (CNT_W = 4): 17 commits to index 3 -> commit_count = 1; the 16th commit leaves it at 0.
